// File: rtl/if_pair_sender.sv
// IF output stage: packs a 64-bit fetch block into two ID lanes behind a 2-entry skid buffer.
// Optional IF_PAIR_SENDER_STAT_EN adds saturating transfer/flush-drop counters.
module if_pair_sender #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int LANE_W = 2 * ADDR_W + INST_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  resp_valid_i,
    output logic                  resp_ready_o,
    input  logic [ADDR_W-1:0]     resp_pc_i,
    input  logic [2*INST_W-1:0]   resp_data_i,
    input  logic                  bp_taken_i,
    input  logic                  bp_slot_i,
    input  logic [ADDR_W-1:0]     bp_target_i,
    input  logic                  allowin_i,
    output logic                  line1_valid_o,
    output logic                  line2_valid_o,
    output logic [2*LANE_W-1:0]   to_id_obus,
    output logic [ADDR_W-1:0]     next_pc_o,
    output logic                  next_pc_valid_o,
`ifdef IF_PAIR_SENDER_STAT_EN
    output logic [31:0]           stat_pair_o,
    output logic [31:0]           stat_single_o,
    output logic [31:0]           stat_flush_drop_o,
`endif
    input  logic                  branch_flush_i,
    input  logic                  excep_flush_i
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    state_t state_nx;

    logic                flush;
    logic                accept;
    logic                xfer;
    logic [ADDR_W-1:0]   base;
    logic                hi;
    logic                pred_app;
    logic                l1_pred;
    logic                l2_pred;
    logic                new_v2;
    logic [LANE_W-1:0]   new_l1;
    logic [LANE_W-1:0]   new_l2;
    logic [2*LANE_W-1:0] skid_bus;
    logic                skid_v2;

    assign flush  = branch_flush_i | excep_flush_i;
    assign accept = resp_valid_i & resp_ready_o & ~flush;
    assign xfer   = line1_valid_o & allowin_i;

    assign base = {resp_pc_i[ADDR_W-1:3], 3'b000};
    assign hi   = resp_pc_i[2];

    always_comb begin
        pred_app = bp_taken_i & (bp_slot_i | ~hi);
        l1_pred  = bp_taken_i & (hi ? bp_slot_i : ~bp_slot_i);
        l2_pred  = bp_taken_i & ~hi & bp_slot_i;
        new_v2   = ~hi & ~(bp_taken_i & ~bp_slot_i);
        new_l1   = {l1_pred ? bp_target_i : {ADDR_W{1'b0}},
                    l1_pred,
                    hi ? resp_data_i[2*INST_W-1:INST_W]
                       : resp_data_i[INST_W-1:0],
                    hi ? base + ADDR_W'(4) : base};
        new_l2   = '0;
        if (new_v2) begin
            new_l2 = {l2_pred ? bp_target_i : {ADDR_W{1'b0}},
                      l2_pred,
                      resp_data_i[2*INST_W-1:INST_W],
                      base + ADDR_W'(4)};
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: state_nx = accept ? ONE : EMPTY;
            ONE: begin
                if (allowin_i) state_nx = accept ? ONE : EMPTY;
                else           state_nx = accept ? TWO : ONE;
            end
            TWO:     state_nx = allowin_i ? ONE : TWO;
            default: state_nx = EMPTY;
        endcase
        if (flush) state_nx = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= EMPTY;
            resp_ready_o    <= 1'b1;
            line1_valid_o   <= 1'b0;
            line2_valid_o   <= 1'b0;
            to_id_obus      <= '0;
            skid_bus        <= '0;
            skid_v2         <= 1'b0;
            next_pc_o       <= '0;
            next_pc_valid_o <= 1'b0;
        end else begin
            state           <= state_nx;
            resp_ready_o    <= (state_nx != TWO);
            next_pc_valid_o <= accept;
            if (accept) begin
                next_pc_o <= pred_app ? bp_target_i : base + ADDR_W'(8);
            end
            // Output reg reloads from skid or the new packet; skid only fills while stalled
            if (flush) begin
                line1_valid_o <= 1'b0;
                line2_valid_o <= 1'b0;
                to_id_obus    <= '0;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (accept) begin
                            line1_valid_o <= 1'b1;
                            line2_valid_o <= new_v2;
                            to_id_obus    <= {new_l2, new_l1};
                        end
                    end
                    ONE: begin
                        if (allowin_i && accept) begin
                            line2_valid_o <= new_v2;
                            to_id_obus    <= {new_l2, new_l1};
                        end else if (allowin_i) begin
                            line1_valid_o <= 1'b0;
                            line2_valid_o <= 1'b0;
                            to_id_obus    <= '0;
                        end else if (accept) begin
                            skid_v2  <= new_v2;
                            skid_bus <= {new_l2, new_l1};
                        end
                    end
                    TWO: begin
                        if (allowin_i) begin
                            line2_valid_o <= skid_v2;
                            to_id_obus    <= skid_bus;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IF_PAIR_SENDER_STAT_EN
    logic [1:0]  drop_n;
    logic [32:0] drop_sum;

    assign drop_n = 2'(state != EMPTY) + 2'(state == TWO) + 2'(resp_valid_i);
    assign drop_sum = {1'b0, stat_flush_drop_o} + 33'(drop_n);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pair_o       <= '0;
            stat_single_o     <= '0;
            stat_flush_drop_o <= '0;
        end else if (flush) begin
            stat_flush_drop_o <= drop_sum[32] ? '1 : drop_sum[31:0];
        end else if (xfer) begin
            if (line2_valid_o && stat_pair_o != '1)
                stat_pair_o <= stat_pair_o + 32'd1;
            if (!line2_valid_o && stat_single_o != '1)
                stat_single_o <= stat_single_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_pair_sender.sv
// Directed bench for if_pair_sender: packing, prediction, skid/backpressure, flush, reset.
// Counter checks compile in when IF_PAIR_SENDER_STAT_EN is defined.
module tb_if_pair_sender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        resp_valid_i;
    logic        resp_ready_o;
    logic [31:0] resp_pc_i;
    logic [63:0] resp_data_i;
    logic        bp_taken_i;
    logic        bp_slot_i;
    logic [31:0] bp_target_i;
    logic        allowin_i;
    logic        line1_valid_o;
    logic        line2_valid_o;
    logic [193:0] to_id_obus;
    logic [31:0] next_pc_o;
    logic        next_pc_valid_o;
    logic        branch_flush_i;
    logic        excep_flush_i;
`ifdef IF_PAIR_SENDER_STAT_EN
    logic [31:0] stat_pair_o;
    logic [31:0] stat_single_o;
    logic [31:0] stat_flush_drop_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    if_pair_sender dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .resp_valid_i    (resp_valid_i),
        .resp_ready_o    (resp_ready_o),
        .resp_pc_i       (resp_pc_i),
        .resp_data_i     (resp_data_i),
        .bp_taken_i      (bp_taken_i),
        .bp_slot_i       (bp_slot_i),
        .bp_target_i     (bp_target_i),
        .allowin_i       (allowin_i),
        .line1_valid_o   (line1_valid_o),
        .line2_valid_o   (line2_valid_o),
        .to_id_obus      (to_id_obus),
        .next_pc_o       (next_pc_o),
        .next_pc_valid_o (next_pc_valid_o),
`ifdef IF_PAIR_SENDER_STAT_EN
        .stat_pair_o       (stat_pair_o),
        .stat_single_o     (stat_single_o),
        .stat_flush_drop_o (stat_flush_drop_o),
`endif
        .branch_flush_i  (branch_flush_i),
        .excep_flush_i   (excep_flush_i)
    );

    always #5 clk = ~clk;

    function automatic logic [96:0] ln(logic [31:0] t, logic p,
                                       logic [31:0] i, logic [31:0] pc);
        return {t, p, i, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        resp_valid_i   = 1'b0;
        resp_pc_i      = '0;
        resp_data_i    = '0;
        bp_taken_i     = 1'b0;
        bp_slot_i      = 1'b0;
        bp_target_i    = '0;
        branch_flush_i = 1'b0;
        excep_flush_i  = 1'b0;
    endtask

    task automatic send(logic [31:0] pc, logic [63:0] d,
                        logic tk, logic sl, logic [31:0] tg);
        resp_valid_i = 1'b1;
        resp_pc_i    = pc;
        resp_data_i  = d;
        bp_taken_i   = tk;
        bp_slot_i    = sl;
        bp_target_i  = tg;
    endtask

    task automatic check_reset_vals(string tag);
        n_cmp += 6;
        if (line1_valid_o !== 1'b0) begin
            n_err++; $display("FAIL %s l1v got %b exp 0", tag, line1_valid_o);
        end
        if (line2_valid_o !== 1'b0) begin
            n_err++; $display("FAIL %s l2v got %b exp 0", tag, line2_valid_o);
        end
        if (to_id_obus !== '0) begin
            n_err++; $display("FAIL %s bus got %h exp 0", tag, to_id_obus);
        end
        if (resp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL %s ready got %b exp 1", tag, resp_ready_o);
        end
        if (next_pc_o !== 32'h0) begin
            n_err++; $display("FAIL %s npc got %h exp 0", tag, next_pc_o);
        end
        if (next_pc_valid_o !== 1'b0) begin
            n_err++; $display("FAIL %s npcv got %b exp 0", tag, next_pc_valid_o);
        end
    endtask

    task automatic test_reset();
        idle();
        allowin_i = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pair();
        send(32'h1C000000, {32'h22, 32'h11}, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        n_cmp += 5;
        if (line1_valid_o !== 1'b1 || line2_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL pair valids got %b%b exp 11", line1_valid_o, line2_valid_o);
        end
        if (to_id_obus !== {ln(0, 0, 32'h22, 32'h1C000004), ln(0, 0, 32'h11, 32'h1C000000)}) begin
            n_err++; $display("FAIL pair bus got %h", to_id_obus);
        end
        if (next_pc_o !== 32'h1C000008) begin
            n_err++; $display("FAIL pair npc got %h exp 1c000008", next_pc_o);
        end
        if (next_pc_valid_o !== 1'b1) begin
            n_err++; $display("FAIL pair npcv got %b exp 1", next_pc_valid_o);
        end
        tick();
        if (line1_valid_o !== 1'b0) begin
            n_err++; $display("FAIL pair drain l1v got %b exp 0", line1_valid_o);
        end
    endtask

    task automatic test_single();
        send(32'h1C000004, {32'h22, 32'h11}, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        n_cmp += 3;
        if (line1_valid_o !== 1'b1 || line2_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL single valids got %b%b exp 10", line1_valid_o, line2_valid_o);
        end
        if (to_id_obus !== {97'h0, ln(0, 0, 32'h22, 32'h1C000004)}) begin
            n_err++; $display("FAIL single bus got %h", to_id_obus);
        end
        if (next_pc_o !== 32'h1C000008) begin
            n_err++; $display("FAIL single npc got %h exp 1c000008", next_pc_o);
        end
        tick();
    endtask

    task automatic test_bp();
        send(32'h1C000000, {32'h22, 32'h11}, 1'b1, 1'b0, 32'h1C000100);
        tick();
        idle();
        n_cmp += 3;
        if (line1_valid_o !== 1'b1 || line2_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp0 valids got %b%b exp 10", line1_valid_o, line2_valid_o);
        end
        if (to_id_obus !== {97'h0, ln(32'h1C000100, 1, 32'h11, 32'h1C000000)}) begin
            n_err++; $display("FAIL bp0 bus got %h", to_id_obus);
        end
        if (next_pc_o !== 32'h1C000100) begin
            n_err++; $display("FAIL bp0 npc got %h exp 1c000100", next_pc_o);
        end
        tick();
        send(32'h1C000000, {32'h22, 32'h11}, 1'b1, 1'b1, 32'h1C000200);
        tick();
        idle();
        n_cmp += 2;
        if (to_id_obus !== {ln(32'h1C000200, 1, 32'h22, 32'h1C000004),
                            ln(0, 0, 32'h11, 32'h1C000000)}) begin
            n_err++; $display("FAIL bp1 bus got %h", to_id_obus);
        end
        if (next_pc_o !== 32'h1C000200) begin
            n_err++; $display("FAIL bp1 npc got %h exp 1c000200", next_pc_o);
        end
        tick();
        send(32'h1C000004, {32'h22, 32'h11}, 1'b1, 1'b0, 32'h1C000300);
        tick();
        idle();
        n_cmp += 2;
        if (to_id_obus !== {97'h0, ln(0, 0, 32'h22, 32'h1C000004)}) begin
            n_err++; $display("FAIL bp_ign bus got %h", to_id_obus);
        end
        if (next_pc_o !== 32'h1C000008) begin
            n_err++; $display("FAIL bp_ign npc got %h exp 1c000008", next_pc_o);
        end
        tick();
    endtask

    task automatic test_wrap();
        send(32'hFFFFFFF8, {32'h44, 32'h33}, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        n_cmp++;
        if (next_pc_o !== 32'h0) begin
            n_err++; $display("FAIL wrap npc got %h exp 0", next_pc_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        allowin_i = 1'b0;
        send(32'h100, {32'hA2, 32'hA1}, 1'b0, 1'b0, 32'h0);
        tick();
        n_cmp += 2;
        if (resp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL b2b ready1 got %b exp 1", resp_ready_o);
        end
        if (to_id_obus !== {ln(0, 0, 32'hA2, 32'h104), ln(0, 0, 32'hA1, 32'h100)}) begin
            n_err++; $display("FAIL b2b busA got %h", to_id_obus);
        end
        send(32'h200, {32'hB2, 32'hB1}, 1'b0, 1'b0, 32'h0);
        tick();
        n_cmp += 3;
        if (resp_ready_o !== 1'b0) begin
            n_err++; $display("FAIL b2b ready2 got %b exp 0", resp_ready_o);
        end
        if (next_pc_o !== 32'h208 || next_pc_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b npcB got %h/%b exp 208/1", next_pc_o, next_pc_valid_o);
        end
        if (to_id_obus !== {ln(0, 0, 32'hA2, 32'h104), ln(0, 0, 32'hA1, 32'h100)}) begin
            n_err++; $display("FAIL b2b holdA got %h", to_id_obus);
        end
        send(32'h300, {32'hC2, 32'hC1}, 1'b0, 1'b0, 32'h0);
        tick();
        n_cmp += 3;
        if (resp_ready_o !== 1'b0) begin
            n_err++; $display("FAIL b2b ready3 got %b exp 0", resp_ready_o);
        end
        if (next_pc_valid_o !== 1'b0 || next_pc_o !== 32'h208) begin
            n_err++;
            $display("FAIL b2b noacceptC got %h/%b exp 208/0", next_pc_o, next_pc_valid_o);
        end
        if (to_id_obus !== {ln(0, 0, 32'hA2, 32'h104), ln(0, 0, 32'hA1, 32'h100)}) begin
            n_err++; $display("FAIL b2b holdA2 got %h", to_id_obus);
        end
        idle();
        allowin_i = 1'b1;
        tick();
        n_cmp += 3;
        if (line1_valid_o !== 1'b1 || line2_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b validsB got %b%b exp 11", line1_valid_o, line2_valid_o);
        end
        if (to_id_obus !== {ln(0, 0, 32'hB2, 32'h204), ln(0, 0, 32'hB1, 32'h200)}) begin
            n_err++; $display("FAIL b2b busB got %h", to_id_obus);
        end
        if (resp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL b2b ready4 got %b exp 1", resp_ready_o);
        end
        tick();
        n_cmp++;
        if (line1_valid_o !== 1'b0) begin
            n_err++; $display("FAIL b2b drained l1v got %b exp 0", line1_valid_o);
        end
    endtask

    task automatic fill_two();
        allowin_i = 1'b0;
        send(32'h100, {32'hA2, 32'hA1}, 1'b0, 1'b0, 32'h0);
        tick();
        send(32'h208, {32'hB2, 32'hB1}, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
    endtask

    task automatic test_flush();
        fill_two();
        n_cmp++;
        if (resp_ready_o !== 1'b0) begin
            n_err++; $display("FAIL flush pre ready got %b exp 0", resp_ready_o);
        end
        send(32'h300, {32'hC2, 32'hC1}, 1'b0, 1'b0, 32'h0);
        branch_flush_i = 1'b1;
        tick();
        idle();
        n_cmp += 4;
        if (line1_valid_o !== 1'b0 || line2_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush valids got %b%b exp 00", line1_valid_o, line2_valid_o);
        end
        if (resp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL flush ready got %b exp 1", resp_ready_o);
        end
        if (next_pc_valid_o !== 1'b0) begin
            n_err++; $display("FAIL flush npcv got %b exp 0", next_pc_valid_o);
        end
        if (to_id_obus !== '0) begin
            n_err++; $display("FAIL flush bus got %h exp 0", to_id_obus);
        end
`ifdef IF_PAIR_SENDER_STAT_EN
        n_cmp++;
        if (stat_flush_drop_o !== 32'd3) begin
            n_err++; $display("FAIL stat_drop got %0d exp 3", stat_flush_drop_o);
        end
`endif
        send(32'h400, {32'hD2, 32'hD1}, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        excep_flush_i = 1'b1;
        tick();
        idle();
        n_cmp += 2;
        if (line1_valid_o !== 1'b0) begin
            n_err++; $display("FAIL xflush l1v got %b exp 0", line1_valid_o);
        end
        if (resp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL xflush ready got %b exp 1", resp_ready_o);
        end
`ifdef IF_PAIR_SENDER_STAT_EN
        n_cmp++;
        if (stat_flush_drop_o !== 32'd4) begin
            n_err++; $display("FAIL stat_drop2 got %0d exp 4", stat_flush_drop_o);
        end
`endif
        allowin_i = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        fill_two();
        n_cmp++;
        if (line1_valid_o !== 1'b1) begin
            n_err++; $display("FAIL rst_mid pre l1v got %b exp 1", line1_valid_o);
        end
        rst_n = 1'b0;
        tick();
        check_reset_vals("rst_mid");
`ifdef IF_PAIR_SENDER_STAT_EN
        n_cmp++;
        if (stat_flush_drop_o !== 32'd0 || stat_pair_o !== 32'd0) begin
            n_err++;
            $display("FAIL rst_mid stats got %0d/%0d exp 0/0", stat_flush_drop_o, stat_pair_o);
        end
`endif
        rst_n = 1'b1;
        allowin_i = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_pair();
        test_single();
        test_bp();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_pair_sender.md
Name: if_pair_sender

Overview:
- Output stage of IF. Packs one 64-bit fetch-block response into up to two instruction lanes, annotated with branch prediction.
- Drives the dual-lane valid and allowin handshake into the IF/ID instruction queue.
- Contains a 2-entry output/skid buffer, so resp_ready_o is registered and allowin_i never reaches the fetch side combinationally.
- Produces the next sequential or predicted fetch PC.

Parameters:
ADDR_W, 32, PC width
INST_W, 32, instruction width; response block = 2*INST_W
LANE_W, 2*ADDR_W+INST_W+1, per-lane bus {pred_target, pred_taken, inst, pc}

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
resp_valid_i  input  1  fetch block response valid
resp_ready_o  output  1  sender can accept a response this cycle (registered)
resp_pc_i  input  ADDR_W  fetch PC; bits [1:0]=0
resp_data_i  input  2*INST_W  [INST_W-1:0] = inst at {pc[ADDR_W-1:3],3'b000}, upper half = inst at +4
bp_taken_i  input  1  prediction for this block: taken
bp_slot_i  input  1  slot holding the predicted-taken branch (0=low word, 1=high word)
bp_target_i  input  ADDR_W  predicted target
allowin_i  input  1  IF/ID queue can take a pair this cycle
line1_valid_o  output  1  lane 1 valid
line2_valid_o  output  1  lane 2 valid; never 1 while line1_valid_o=0
to_id_obus  output  2*LANE_W  {lane2, lane1}
next_pc_o  output  ADDR_W  next fetch PC after the last accepted block
next_pc_valid_o  output  1  pulse: next_pc_o updated this cycle
branch_flush_i  input  1  branch-mispredict flush
excep_flush_i  input  1  exception flush

Behaviour:
- Reset: line1/line2_valid_o=0; to_id_obus=0; resp_ready_o=1; next_pc_o=0; next_pc_valid_o=0; state EMPTY.
- Accept: resp_valid_i & resp_ready_o & no flush.
- Slot packing at accept; a = {resp_pc_i[ADDR_W-1:3],3'b000}.
  - pc[2]=0: lane1={a, low word}, lane2={a+4, high word}.
    - lane2 valid unless bp_taken_i & bp_slot_i=0.
    - If bp_taken_i & bp_slot_i=0: lane1 carries pred_taken=1 and target.
    - If bp_taken_i & bp_slot_i=1: lane2 carries them.
  - pc[2]=1: lane1={a+4, high word}, lane2 invalid. Prediction applies only if bp_slot_i=1; bp_slot_i=0 is ignored.
  - pred_target is zero on any lane with pred_taken=0.
- next_pc_o: registered on accept.
  - If a prediction applied to any valid lane: bp_target_i.
  - Else: a+8, wraps modulo 2^ADDR_W.
  - next_pc_valid_o pulses 1 cycle with it.
- States: EMPTY, ONE (output reg valid), TWO (output + skid valid).
  - EMPTY: accept -> ONE; packet in output reg, visible the next cycle.
  - ONE, allowin_i & accept: output reg <= new packet; stay ONE.
  - ONE, allowin_i & no accept: -> EMPTY.
  - ONE, !allowin_i & accept: packet into skid -> TWO.
  - TWO, allowin_i: output reg <= skid -> ONE. No accept is possible in TWO.
- Ready: resp_ready_o = (next state != TWO), registered. Latency response -> lane valid = 1 cycle.
- Transfer: a pair leaves when line1_valid_o & allowin_i; both lanes transfer together, never split.
- Flush (either flush input, any state): next cycle state EMPTY, both valids 0, buffer contents dropped.
  - A response presented in the flush cycle is dropped; next_pc_valid_o stays 0.
  - resp_ready_o = 1 after the flush.
- Flush has priority over accept and transfer. Reset has priority over flush.
- Outputs are held stable while line1_valid_o & !allowin_i.

Optional Feature:
IF_PAIR_SENDER_STAT_EN
- Defined: three 32-bit counters, cleared at reset only, saturating at max; ports stat_pair_o, stat_single_o, stat_flush_drop_o.
  - stat_pair_o: pairs transferred with both lanes valid.
  - stat_single_o: pairs transferred with lane1 only.
  - stat_flush_drop_o: valid packets discarded by flush, counting buffered packets plus one for a response presented in the flush cycle.
- Not defined: counters and ports are absent; all other behaviour is identical.

Test Plan:
- pc=0x1C000000, data={0x22,0x11}, no bp, allowin=1 -> next cycle: lane1={0x1C000000,0x11}, lane2={0x1C000004,0x22}, both valid; next_pc_o=0x1C000008.
- pc=0x1C000004, data={0x22,0x11} -> line1 valid={0x1C000004,0x22}, line2_valid=0; next_pc_o=0x1C000008.
- pc=0x1C000000, bp_taken=1, slot=0, target=0x1C000100 -> only lane1 valid, pred_taken=1, target 0x1C000100; next_pc_o=0x1C000100.
- allowin=0 while 3 back-to-back responses arrive -> 2 accepted, resp_ready_o=0 from the cycle after the 2nd accept. Raise allowin -> packets leave in order A then B, no loss or duplication.
- State TWO, branch_flush_i=1 for 1 cycle with resp_valid_i=1 -> next cycle both valids 0, resp_ready_o=1, next_pc_valid_o=0. With IF_PAIR_SENDER_STAT_EN, stat_flush_drop_o increments by 3.
- pc=0xFFFFFFF8, no bp -> next_pc_o=0x00000000. rst_n=0 mid-TWO -> all outputs back to reset values next cycle.
